// File: rtl/flash_audio_streamer.sv
`default_nettype none
// ============================================================================
// Module      : flash_audio_streamer
// Description : Streams PCM samples from flash over an Avalon-MM read master.
//               It emits one sample per sample_tick and keeps one prefetched
//               word. Define FLASH_STREAM_VOLUME_EN to add the volume[2:0]
//               input, which attenuates each sample by an arithmetic shift.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_audio_streamer #(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 32,
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_tick,
    input  logic                pause,
    input  logic                reverse,
    input  logic                loop_en,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    input  logic                restart,
`ifdef FLASH_STREAM_VOLUME_EN
    input  logic [2:0]          volume,
`endif
    output logic                flash_mem_read,
    output logic [ADDR_W-1:0]   flash_mem_address,
    output logic [5:0]          flash_mem_burstcount,
    output logic [3:0]          flash_mem_byteenable,
    input  logic                flash_mem_waitrequest,
    input  logic [DATA_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    output logic [SAMPLE_W-1:0] audio_sample,
    output logic                sample_valid,
    output logic                done,
    output logic                overrun
);

    localparam logic [5:0] c_burst_one  = 6'd1;
    localparam logic [3:0] c_all_bytes  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_DATA = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_read;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_loaded;
    logic                r_dir;
    logic [DATA_W-1:0]   r_buf;
    logic                r_full;
    logic                r_half;
    logic                r_pending;
    logic                r_discard;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_valid;
    logic                r_done;
    logic                r_overrun;

    logic                w_run;
    logic                w_tick;
    logic                w_demand;
    logic                w_drop;
    logic                w_land;
    logic                w_launch;
    logic                w_edge;
    logic [ADDR_W-1:0]   w_fetch_addr;
    logic [ADDR_W-1:0]   w_next_ptr;
    logic [15:0]         w_land_half;
    logic [15:0]         w_buf_half;
    logic [2:0]          w_vol;

`ifdef FLASH_STREAM_VOLUME_EN
    assign w_vol = volume;
`else
    assign w_vol = 3'd0;
`endif

    function automatic logic [SAMPLE_W-1:0] f_trim(input logic [15:0] half,
                                                   input logic [2:0]  vol);
        logic signed [15:0] scaled;
        scaled = $signed(half) >>> vol;
        return scaled[15:16-SAMPLE_W];
    endfunction

    // A pended tick counts as demand only while playback is allowed to advance.
    assign w_run    = !pause && !r_done && !restart;
    assign w_tick   = sample_tick && w_run;
    assign w_demand = w_tick || (r_pending && w_run);
    assign w_drop   = w_tick && r_pending;

    assign w_land   = (r_state == S_WAIT_DATA) && flash_mem_readdatavalid
                      && !r_discard && !restart;
    assign w_launch = (r_state == S_IDLE) && !r_full && !r_done && !restart;

    assign w_fetch_addr = r_loaded ? r_ptr : start_addr;

    // First half of a word depends on the direction latched for that word.
    assign w_land_half = r_dir ? flash_mem_readdata[31:16] : flash_mem_readdata[15:0];
    assign w_buf_half  = (r_dir ^ r_half) ? r_buf[31:16] : r_buf[15:0];

    always_comb begin
        w_edge     = 1'b0;
        w_next_ptr = r_ptr;
        if (reverse) begin
            w_edge     = (r_ptr <= start_addr);
            w_next_ptr = w_edge ? end_addr : (r_ptr - 1'b1);
        end else begin
            w_edge     = (r_ptr >= end_addr);
            w_next_ptr = w_edge ? start_addr : (r_ptr + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_read    <= 1'b0;
            r_addr    <= '0;
            r_ptr     <= '0;
            r_loaded  <= 1'b0;
            r_dir     <= 1'b0;
            r_buf     <= '0;
            r_full    <= 1'b0;
            r_half    <= 1'b0;
            r_pending <= 1'b0;
            r_discard <= 1'b0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_REQ;
                        r_read  <= 1'b1;
                        r_addr  <= w_fetch_addr;
                        if (!r_loaded) begin
                            r_ptr    <= start_addr;
                            r_loaded <= 1'b1;
                            r_dir    <= reverse;
                        end
                    end
                end
                S_REQ: begin
                    if (!flash_mem_waitrequest) begin
                        r_state <= S_WAIT_DATA;
                        r_read  <= 1'b0;
                    end
                end
                S_WAIT_DATA: begin
                    if (flash_mem_readdatavalid) begin
                        r_state   <= S_IDLE;
                        r_discard <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_read  <= 1'b0;
                end
            endcase

            if (w_land) begin
                r_buf  <= flash_mem_readdata;
                r_full <= 1'b1;
                r_half <= w_demand;
            end

            // A waiting tick is served straight from the bus in the landing cycle.
            if (w_land && w_demand) begin
                r_sample  <= f_trim(w_land_half, w_vol);
                r_valid   <= 1'b1;
                r_pending <= 1'b0;
            end else if (r_full && w_demand) begin
                r_sample  <= f_trim(w_buf_half, w_vol);
                r_valid   <= 1'b1;
                r_pending <= 1'b0;
                if (!r_half) begin
                    r_half <= 1'b1;
                end else begin
                    r_half <= 1'b0;
                    r_full <= 1'b0;
                    r_dir  <= reverse;
                    if (w_edge && !loop_en) begin
                        r_done <= 1'b1;
                    end else begin
                        r_ptr <= w_next_ptr;
                    end
                end
            end else if (w_tick) begin
                r_pending <= 1'b1;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end

            // An accepted or still-stalled read must finish on the bus; its data is dropped.
            if (restart) begin
                r_loaded  <= 1'b0;
                r_full    <= 1'b0;
                r_half    <= 1'b0;
                r_pending <= 1'b0;
                r_done    <= 1'b0;
                r_overrun <= 1'b0;
                r_valid   <= 1'b0;
                r_discard <= (r_state == S_REQ)
                             || ((r_state == S_WAIT_DATA) && !flash_mem_readdatavalid);
            end
        end
    end

    // Outside a request the address previews the next fetch location.
    assign flash_mem_address    = (r_state == S_REQ) ? r_addr : w_fetch_addr;
    assign flash_mem_read       = r_read;
    assign flash_mem_burstcount = c_burst_one;
    assign flash_mem_byteenable = c_all_bytes;
    assign audio_sample         = r_sample;
    assign sample_valid         = r_valid;
    assign done                 = r_done;
    assign overrun              = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_flash_audio_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_audio_streamer
// Description : Bench for flash_audio_streamer. It pairs a flash slave with
//               random stalls and latency with a word/half sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_audio_streamer;

    localparam int ADDR_W = 23;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              sample_tick;
    logic              pause;
    logic              reverse;
    logic              loop_en;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              restart;
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [5:0]        flash_mem_burstcount;
    logic [3:0]        flash_mem_byteenable;
    logic              flash_mem_waitrequest;
    logic [31:0]       flash_mem_readdata;
    logic              flash_mem_readdatavalid;
    logic [7:0]        audio_sample;
    logic              sample_valid;
    logic              done;
    logic              overrun;
`ifdef FLASH_STREAM_VOLUME_EN
    logic [2:0]        volume = 3'd0;
`endif

    always #5 clk = ~clk;

    flash_audio_streamer dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .sample_tick             (sample_tick),
        .pause                   (pause),
        .reverse                 (reverse),
        .loop_en                 (loop_en),
        .start_addr              (start_addr),
        .end_addr                (end_addr),
        .restart                 (restart),
`ifdef FLASH_STREAM_VOLUME_EN
        .volume                  (volume),
`endif
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_burstcount    (flash_mem_burstcount),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .audio_sample            (audio_sample),
        .sample_valid            (sample_valid),
        .done                    (done),
        .overrun                 (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash contents and playback model
    logic [31:0] mem [0:63];
    int          m_addr, m_start, m_end;
    bit          m_half, m_rev;
    int          n_valid = 0;

    task automatic model_set(input int s, input int e, input bit rev);
        m_start = s;
        m_end   = e;
        m_addr  = s;
        m_half  = 1'b0;
        m_rev   = rev;
    endtask

    task automatic model_pop(output logic [7:0] s);
        logic [31:0] w;
        logic [15:0] h;
        w = mem[m_addr % 64];
        h = (m_half == m_rev) ? w[15:0] : w[31:16];
        s = h[15:8];
        if (m_half) begin
            if (!m_rev) m_addr = (m_addr >= m_end) ? m_start : m_addr + 1;
            else        m_addr = (m_addr <= m_start) ? m_end : m_addr - 1;
        end
        m_half = !m_half;
    endtask

    initial begin
        logic [7:0] exp_s;
        forever begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                model_pop(exp_s);
                chk("sample", {24'd0, audio_sample}, {24'd0, exp_s});
                n_valid++;
            end
        end
    end

    // Avalon slave: per-request stall, fixed latency, one read outstanding
    int                stall_cfg = 0;
    int                lat_cfg   = 1;
    int                stall_cnt = 0;
    int                lat_cnt   = 0;
    bit                busy      = 1'b0;
    bit                prev_read = 1'b0;
    logic [ADDR_W-1:0] busy_addr;
    logic [ADDR_W-1:0] acc_q [$];

    initial begin
        flash_mem_waitrequest   = 1'b1;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = '0;
        forever begin
            @(negedge clk);
            flash_mem_readdatavalid = 1'b0;
            if (busy) begin
                if (lat_cnt == 0) begin
                    flash_mem_readdatavalid = 1'b1;
                    flash_mem_readdata      = mem[busy_addr % 64];
                    busy                    = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            if (flash_mem_read === 1'b1) begin
                if (!prev_read) stall_cnt = stall_cfg;
                if (busy || stall_cnt > 0) begin
                    flash_mem_waitrequest = 1'b1;
                    if (!busy) stall_cnt--;
                end else begin
                    flash_mem_waitrequest = 1'b0;
                    busy      = 1'b1;
                    busy_addr = flash_mem_address;
                    lat_cnt   = lat_cfg;
                    acc_q.push_back(flash_mem_address);
                end
            end else begin
                flash_mem_waitrequest = 1'b1;
            end
            prev_read = (flash_mem_read === 1'b1);
        end
    end

    task automatic tick(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic play(input int s, input int e, input bit lp, input bit rev);
        start_addr = ADDR_W'(s);
        end_addr   = ADDR_W'(e);
        loop_en    = lp;
        reverse    = rev;
        restart    = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        model_set(s, e, rev);
        acc_q.delete();
        repeat (12) @(negedge clk);
    endtask

    task automatic chk_addrs(input string tag, input int a0, input int a1, input int a2, input int a3);
        int exp_a [4];
        exp_a = '{a0, a1, a2, a3};
        for (int i = 0; i < 4; i++) begin
            chk(tag, (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hFFFF_FFFF, 32'(exp_a[i]));
        end
    endtask

    initial begin
        int          v0, seen, s, len, nt, exp_n;
        bit          lp, rev;
        logic [7:0]  s0;

        reset_n = 1'b0;  sample_tick = 1'b0; pause = 1'b0; reverse = 1'b0;
        loop_en = 1'b1;  start_addr = 23'd50; end_addr = 23'd52; restart = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[50] = 32'h0200_0100;
        mem[60] = 32'h0A00_0B00;
        mem[10] = 32'h3344_5566;
        mem[11] = 32'h7788_99AA;
        model_set(50, 52, 1'b0);
        repeat (3) @(negedge clk);

        chk("rst_read",    {31'd0, flash_mem_read}, 32'd0);
        chk("rst_addr",    32'(flash_mem_address), 32'd50);
        chk("rst_sample",  {24'd0, audio_sample}, 32'd0);
        chk("rst_valid",   {31'd0, sample_valid}, 32'd0);
        chk("rst_done",    {31'd0, done}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("burstcount",  {26'd0, flash_mem_burstcount}, 32'd1);
        chk("byteenable",  {28'd0, flash_mem_byteenable}, 32'hF);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);

        // Forward loop over a three-word window
        v0 = n_valid;
        tick(8, 12);
        chk("t1_count", n_valid - v0, 8);
        chk_addrs("t1_addr", 50, 51, 52, 50);
        chk("t1_overrun", {31'd0, overrun}, 32'd0);

        // One-shot stops after the last word
        play(50, 51, 1'b0, 1'b0);
        v0 = n_valid;
        tick(6, 12);
        chk("t2_count", n_valid - v0, 4);
        chk("t2_done", {31'd0, done}, 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (flash_mem_read === 1'b1) seen++;
        end
        chk("t2_read_idle", seen, 0);
        chk("t2_fetches", acc_q.size(), 2);

        // Reverse playback wraps from below start to end
        play(60, 62, 1'b1, 1'b1);
        v0 = n_valid;
        tick(8, 12);
        chk("t3_count", n_valid - v0, 8);
        chk_addrs("t3_addr", 60, 62, 61, 60);

        // Pause discards ticks and holds the output
        play(50, 52, 1'b1, 1'b0);
        v0 = n_valid;
        tick(1, 12);
        s0 = audio_sample;
        pause = 1'b1;
        tick(5, 4);
        chk("t4_paused_count", n_valid - v0, 1);
        chk("t4_paused_hold", {24'd0, audio_sample}, {24'd0, s0});
        pause = 1'b0;
        tick(1, 12);
        chk("t4_resume_count", n_valid - v0, 2);

        // Stalled fetch: one tick pended, the next dropped
        stall_cfg = 0; lat_cfg = 1;
        play(50, 52, 1'b1, 1'b0);
        v0 = n_valid;
        tick(1, 3);
        stall_cfg = 10;
        tick(1, 3);
        tick(2, 3);
        repeat (30) @(negedge clk);
        chk("t5_count", n_valid - v0, 3);
        chk("t5_overrun", {31'd0, overrun}, 32'd1);
        stall_cfg = 0;
        play(50, 52, 1'b1, 1'b0);
        chk("t5_overrun_clear", {31'd0, overrun}, 32'd0);

        // Reset during an outstanding read; the late data must be ignored
        play(10, 12, 1'b1, 1'b0);
        lat_cfg = 8;
        tick(2, 1);
        for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
        chk("t6_fetch_started", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_read",   {31'd0, flash_mem_read}, 32'd0);
        chk("t6_rst_sample", {24'd0, audio_sample}, 32'd0);
        chk("t6_rst_done",   {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_set(10, 12, 1'b0);
        lat_cfg = 1;
        v0 = n_valid;
        tick(4, 16);
        chk("t6_count", n_valid - v0, 4);

        // Single-word window
        play(40, 40, 1'b1, 1'b0);
        v0 = n_valid;
        tick(6, 12);
        chk("t7_count", n_valid - v0, 6);

        // Randomized windows, directions, modes and bus timing
        for (int it = 0; it < 8; it++) begin
            s   = $urandom_range(0, 58);
            len = $urandom_range(0, 3);
            lp  = 1'($urandom_range(0, 1));
            rev = 1'($urandom_range(0, 1));
            nt  = $urandom_range(1, 12);
            stall_cfg = $urandom_range(0, 2);
            lat_cfg   = $urandom_range(0, 3);
            play(s, s + len, lp, rev);
            v0 = n_valid;
            tick(nt, 14);
            repeat (4) @(negedge clk);
            exp_n = lp ? nt : ((nt < 2 * (rev ? 1 : len + 1)) ? nt : 2 * (rev ? 1 : len + 1));
            chk("rand_count", n_valid - v0, exp_n);
            chk("rand_done", {31'd0, done}, {31'd0, (!lp && nt >= 2 * (rev ? 1 : len + 1))});
            chk("rand_overrun", {31'd0, overrun}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
